// File: rtl/countdown_pkg.sv
// Shared encodings for the mm:ss cook-time down counter.
package countdown_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int SEC_MAX = 59;

  // Clamp a raw seconds entry to the largest legal seconds value.
  function automatic logic [5:0] sat_sec(input logic [5:0] s);
    return (s > 6'(SEC_MAX)) ? 6'(SEC_MAX) : s;
  endfunction

endpackage

// File: rtl/down_counter_modn.sv
// Modulo-N down counter: clear, load, decrement with wrap and borrow strobe.
module down_counter_modn #(
  parameter int N = 60,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] val,
  output logic         zero,
  output logic         borrow_out
);

  logic [W-1:0] val_q;

  assign val        = val_q;
  assign zero       = (val_q == '0);
  // Borrow only when a decrement actually happens at zero (clear/load win).
  assign borrow_out = dec & zero & ~ld & ~clr;

  // Counter register: clear > load > decrement, wrapping 0 -> N-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          val_q <= '0;
    else if (clr)      val_q <= '0;
    else if (ld)       val_q <= ld_val;
    else if (dec)      val_q <= zero ? W'(N - 1) : val_q - W'(1);
  end

endmodule

// File: rtl/countdown_timer_mmss.sv
// Microwave cook-time down counter: loads mm:ss, counts down on 1 Hz ticks,
// stops at 00:00 and flags completion.
module countdown_timer_mmss
  import countdown_pkg::*;
#(
  parameter int MAX_MIN = 99,
  parameter int MIN_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [5:0]       load_sec,
  input  logic             start,
  input  logic             pause,
  input  logic             cancel,
  input  logic             door_open,
  output logic [MIN_W-1:0] min,
  output logic [5:0]       sec,
  output logic [2:0]       state,
  output logic             running,
  output logic             paused,
  output logic             done,
  output logic             done_pulse
);

  localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);

  state_e           state_q, state_d;
  logic [MIN_W-1:0] min_q;
  logic [MIN_W-1:0] min_clamp;
  logic [5:0]       sec_clamp;
  logic [5:0]       sec_val;
  logic             sec_zero, sec_borrow;
  logic             ld_c, clr_c, dec_c, done_evt;
  logic             running_q, paused_q, done_q, done_pulse_q;
  logic             running_d, paused_d, done_d, done_pulse_d;

  assign min_clamp = (load_min > MAX_MIN_V) ? MAX_MIN_V : load_min;
  assign sec_clamp = sat_sec(load_sec);

  down_counter_modn #(.N(SEC_MAX + 1), .W(6)) u_sec (
    .clk        (clk),
    .rst        (rst),
    .ld         (ld_c),
    .ld_val     (sec_clamp),
    .dec        (dec_c),
    .clr        (clr_c),
    .val        (sec_val),
    .zero       (sec_zero),
    .borrow_out (sec_borrow)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and counter controls, priority cancel > load > door > start > pause > tick.
  // A request that does not apply in the current state falls through to lower ones.
  always_comb begin
    state_d  = state_q;
    ld_c     = 1'b0;
    clr_c    = 1'b0;
    dec_c    = 1'b0;
    done_evt = 1'b0;
    if (cancel) begin
      clr_c   = 1'b1;
      state_d = IDLE;
    end else if (load && state_q != RUN) begin
      ld_c    = 1'b1;
      state_d = (min_clamp == '0 && sec_clamp == '0) ? IDLE : ARMED;
    end else if (door_open && state_q == RUN) begin
      state_d = PAUSE;
    end else if (start && !door_open && (state_q == ARMED || state_q == PAUSE)) begin
      state_d = RUN;
    end else if (pause && state_q == RUN) begin
      state_d = PAUSE;
    end else if (tick && !door_open && state_q == RUN && !(min_q == '0 && sec_zero)) begin
      dec_c = 1'b1;
      if (min_q == '0 && sec_val == 6'd1) begin
        state_d  = DONE;
        done_evt = 1'b1;
      end
    end
  end

  // Registered flag values derived from the upcoming state.
  always_comb begin
    running_d    = (state_d == RUN);
    paused_d     = (state_d == PAUSE);
    done_d       = (state_d == DONE);
    done_pulse_d = done_evt;
  end

  // Flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running_q    <= 1'b0;
      paused_q     <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      running_q    <= running_d;
      paused_q     <= paused_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  // Minutes: saturating down register driven by the seconds borrow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          min_q <= '0;
    else if (clr_c)                    min_q <= '0;
    else if (ld_c)                     min_q <= min_clamp;
    else if (sec_borrow && min_q != '0) min_q <= min_q - MIN_W'(1);
  end

  assign min        = min_q;
  assign sec        = sec_val;
  assign state      = state_q;
  assign running    = running_q;
  assign paused     = paused_q;
  assign done       = done_q;
  assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Directed bench for countdown_timer_mmss with an expectation queue.
module tb_countdown_timer_mmss;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic       cancel = 1'b0, door_open = 1'b0;
  logic [6:0] load_min = '0;
  logic [5:0] load_sec = '0;
  logic [6:0] min;
  logic [5:0] sec;
  logic [2:0] state;
  logic       running, paused, done, done_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [6:0] m;
    logic [5:0] s;
    logic [2:0] st;
    logic       dp;
    string      tag;
  } exp_t;

  exp_t sb[$];

  countdown_timer_mmss #(.MAX_MIN(99), .MIN_W(7)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .load_min(load_min),
    .load_sec(load_sec), .start(start), .pause(pause), .cancel(cancel),
    .door_open(door_open), .min(min), .sec(sec), .state(state),
    .running(running), .paused(paused), .done(done), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  // Pop the oldest expectation and compare against the live outputs.
  task automatic check_head();
    exp_t e;
    logic [15:0] obs, want;
    e = sb.pop_front();
    obs  = {min, sec, state};
    want = {e.m, e.s, e.st};
    n_cmp++;
    assert (obs === want && running === (e.st == 3'd2) && paused === (e.st == 3'd3)
            && done === (e.st == 3'd4) && done_pulse === e.dp)
    else begin
      n_bad++;
      $error("FAIL %s: got %0d:%0d st=%0d r%0b p%0b d%0b dp%0b, want %0d:%0d st=%0d dp%0b",
             e.tag, min, sec, state, running, paused, done, done_pulse,
             e.m, e.s, e.st, e.dp);
    end
  endtask

  // One clock: drive pulses, queue what should appear, sample after the edge.
  task automatic step(input logic ti, input logic ld, input logic [6:0] lm,
                      input logic [5:0] ls, input logic st, input logic pa,
                      input logic ca, input logic [6:0] em, input logic [5:0] es,
                      input logic [2:0] est, input logic edp, input string tag);
    exp_t e;
    tick = ti; load = ld; load_min = lm; load_sec = ls;
    start = st; pause = pa; cancel = ca;
    e.m = em; e.s = es; e.st = est; e.dp = edp; e.tag = tag;
    sb.push_back(e);
    @(posedge clk); #1;
    tick = 0; load = 0; start = 0; pause = 0; cancel = 0;
    check_head();
  endtask

  initial begin
    exp_t e;
    // Reset state while held.
    #3;
    e.m = 0; e.s = 0; e.st = 0; e.dp = 0; e.tag = "reset"; sb.push_back(e);
    check_head();
    #14 rst = 1'b1;
    @(posedge clk); #1;

    // Basic countdown to done.
    step(0,1,0,3,0,0,0, 0,3,1,0,"load_0003");
    step(0,0,0,0,1,0,0, 0,3,2,0,"start");
    step(1,0,0,0,0,0,0, 0,2,2,0,"tick_0002");
    step(1,0,0,0,0,0,0, 0,1,2,0,"tick_0001");
    step(1,0,0,0,0,0,0, 0,0,4,1,"tick_done");
    for (int i = 0; i < 5; i++) step(1,0,0,0,0,0,0, 0,0,4,0,"done_hold");
    step(0,0,0,0,0,0,0, 0,0,4,0,"done_idle");
    step(0,0,0,0,0,0,1, 0,0,0,0,"cancel");
    step(0,0,0,0,1,0,0, 0,0,0,0,"start_idle");

    // Minute borrow.
    step(0,1,2,0,0,0,0, 2,0,1,0,"load_0200");
    step(0,0,0,0,1,0,0, 2,0,2,0,"start2");
    step(1,0,0,0,0,0,0, 1,59,2,0,"borrow");
    for (int i = 1; i <= 60; i++)
      step(1,0,0,0,0,0,0, 7'((119 - i) / 60), 6'((119 - i) % 60), 2, 0, "count");
    step(0,0,0,0,0,0,1, 0,0,0,0,"cancel2");

    // Door interlock.
    step(0,1,0,10,0,0,0, 0,10,1,0,"load_0010");
    step(0,0,0,0,1,0,0, 0,10,2,0,"start3");
    door_open = 1'b1;
    step(0,0,0,0,0,0,0, 0,10,3,0,"door_pause");
    for (int i = 0; i < 3; i++) step(1,0,0,0,0,0,0, 0,10,3,0,"door_tick");
    step(0,0,0,0,1,0,0, 0,10,3,0,"door_start");
    door_open = 1'b0;
    step(0,0,0,0,0,0,0, 0,10,3,0,"door_closed");
    step(0,0,0,0,1,0,0, 0,10,2,0,"resume");
    step(1,0,0,0,0,0,0, 0,9,2,0,"tick_0009");

    // Priority and clamping.
    step(0,0,0,0,0,0,1, 0,0,0,0,"cancel3");
    step(0,1,120,63,0,0,0, 99,59,1,0,"clamp");
    step(0,1,5,5,0,0,1, 0,0,0,0,"cancel_load");
    step(0,1,0,0,0,0,0, 0,0,0,0,"load_zero");
    step(0,1,0,5,0,0,0, 0,5,1,0,"load_0005");
    step(1,0,0,0,1,0,0, 0,5,2,0,"start_tick");
    step(1,0,0,0,0,0,0, 0,4,2,0,"tick_0004");
    step(1,0,0,0,0,1,0, 0,4,3,0,"pause_tick");
    step(1,0,0,0,0,0,0, 0,4,3,0,"paused_tick");
    step(0,1,0,20,0,0,0, 0,20,1,0,"load_pause");
    step(0,0,0,0,1,0,0, 0,20,2,0,"start4");
    step(0,1,5,0,0,0,0, 0,20,2,0,"load_run");
    step(1,0,0,0,0,0,0, 0,19,2,0,"tick_0019");

    // Reset mid-run.
    step(0,0,0,0,0,0,1, 0,0,0,0,"cancel4");
    step(0,1,1,30,0,0,0, 1,30,1,0,"load_0130");
    step(0,0,0,0,1,0,0, 1,30,2,0,"start5");
    #2 rst = 1'b0;
    #1;
    e.m = 0; e.s = 0; e.st = 0; e.dp = 0; e.tag = "async_rst"; sb.push_back(e);
    check_head();
    #1 rst = 1'b1;
    @(posedge clk); #1;
    step(1,0,0,0,0,0,0, 0,0,0,0,"post_rst_tick");
    step(1,0,0,0,0,0,0, 0,0,0,0,"post_rst_tick2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
